pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// PC sequencer: boot vector fetch, jump/return/interrupt control and the
// stack push/pop strobes, decoded from a small FSM with a wait counter.
module pc_sequencer #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       jump,
  input  logic       ret,
  input  logic       rti,
  input  logic       intr,
  output logic [1:0] pc_src,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       vec_rd,
  output logic       vec_sel,
  output logic       stack_push,
  output logic       stack_pop,
  output logic       flush,
  output logic       int_ack,
  output logic       int_en
);

  typedef enum logic [2:0] {
    StBoot,
    StRun,
    StIntPush,
    StIntVec,
    StRetPop,
    StRetLd
  } state_e;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_e     r_state, w_state_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic       r_int_en, w_int_en_next;
  logic       r_rti, w_rti_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StBoot;
      r_cnt    <= 3'd0;
      r_int_en <= 1'b0;
      r_rti    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_int_en <= w_int_en_next;
      r_rti    <= w_rti_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_int_en_next = r_int_en;
    w_rti_next    = r_rti;
    pc_src        = 2'b00;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    vec_rd        = 1'b0;
    vec_sel       = 1'b0;
    stack_push    = 1'b0;
    stack_pop     = 1'b0;
    flush         = 1'b0;
    int_ack       = 1'b0;

    unique case (r_state)
      StBoot: begin
        if (r_cnt < LAT) begin
          vec_rd     = 1'b1;
          w_cnt_next = r_cnt + 3'd1;
        end else begin
          pc_load       = 1'b1;
          w_cnt_next    = 3'd0;
          w_int_en_next = 1'b1;
          w_state_next  = StRun;
        end
      end
      StRun: begin
        if (ret) begin
          stack_pop    = 1'b1;
          flush        = 1'b1;
          w_rti_next   = rti;
          w_state_next = StRetPop;
        end else if (jump) begin
          pc_src  = 2'b10;
          pc_load = 1'b1;
          flush   = 1'b1;
        end else if (intr && r_int_en) begin
          // Accepting an interrupt overrides stall.
          int_ack       = 1'b1;
          flush         = 1'b1;
          w_int_en_next = 1'b0;
          w_state_next  = StIntPush;
        end else if (!stall) begin
          pc_inc = 1'b1;
        end
      end
      StIntPush: begin
        stack_push   = 1'b1;
        w_cnt_next   = 3'd0;
        w_state_next = StIntVec;
      end
      StIntVec: begin
        if (r_cnt < LAT) begin
          vec_rd     = 1'b1;
          vec_sel    = 1'b1;
          w_cnt_next = r_cnt + 3'd1;
        end else begin
          pc_src       = 2'b01;
          pc_load      = 1'b1;
          w_cnt_next   = 3'd0;
          w_state_next = StRun;
        end
      end
      StRetPop: begin
        // Idle cycle: stack_val becomes valid for the load that follows.
        w_state_next = StRetLd;
      end
      StRetLd: begin
        pc_src       = 2'b11;
        pc_load      = 1'b1;
        if (r_rti) begin
          w_int_en_next = 1'b1;
        end
        w_state_next = StRun;
      end
      default: begin
        w_state_next = StBoot;
        w_cnt_next   = 3'd0;
      end
    endcase
  end

  assign int_en = r_int_en;

endmodule
